serial_paralelo_com: RTL and testbench

//  Receive-side deserializer directly downstream of paralelo_serial: takes the 1-bit serial lane at clk_32f,

---
 rtl/serial_paralelo_com_pkg.sv | 16 +
 rtl/serial_paralelo_com.sv | 111 +++++++++++
 tb/tb_serial_paralelo_com.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_paralelo_com_pkg.sv
// Shared definitions for the serial-to-parallel receive deserializer.
// COM character, lock threshold default and the alignment FSM encoding.
package serial_paralelo_com_pkg;

    localparam logic [7:0] COM_CHAR      = 8'hBC;
    localparam int         COM_COUNT_DEF = 4;
    localparam int         CNT_W         = 4;
    localparam int         BIT_W         = 3;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_paralelo_com.sv
// Receive deserializer: hunts for the COM character bit by bit, locks
// byte phase after COM_COUNT aligned COMs, then emits aligned bytes.
module serial_paralelo_com
    import serial_paralelo_com_pkg::*;
#(
    parameter logic [7:0] COM       = COM_CHAR,
    parameter int         COM_COUNT = COM_COUNT_DEF
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(COM_COUNT);
    localparam logic [BIT_W-1:0] LAST_BIT = '1;

    state_t             state;
    state_t             state_d;
    logic [6:0]         sr;
    logic [7:0]         sr_next;
    logic [BIT_W-1:0]   bit_cnt;
    logic [BIT_W-1:0]   bit_cnt_d;
    logic [CNT_W-1:0]   com_cnt;
    logic [CNT_W-1:0]   com_cnt_d;
    logic [CNT_W-1:0]   com_cnt_inc;
    logic [7:0]         data_d;
    logic               valid_d;
    logic               strobe_d;
    logic               boundary;
    logic               is_com;

    // Only seven bits of history are kept; the eighth is the live input.
    assign sr_next     = {sr, data_in};
    assign is_com      = (sr_next == COM);
    assign boundary    = (bit_cnt == LAST_BIT);
    assign com_cnt_inc = (com_cnt >= CNT_MAX) ? CNT_MAX
                                              : com_cnt + 1'b1;

    always_comb begin
        state_d   = SEARCH;
        bit_cnt_d = bit_cnt;
        com_cnt_d = com_cnt;
        data_d    = data_out;
        valid_d   = valid_out;
        strobe_d  = 1'b0;
        case (state)
            SEARCH: begin
                state_d = SEARCH;
                if (is_com) begin
                    bit_cnt_d = '0;
                    com_cnt_d = CNT_W'(1);
                    state_d   = (COM_COUNT == 1) ? ACTIVE : LOCKING;
                end
            end
            LOCKING: begin
                state_d   = LOCKING;
                bit_cnt_d = bit_cnt + 1'b1;
                if (boundary) begin
                    if (is_com) begin
                        com_cnt_d = com_cnt_inc;
                        if (com_cnt_inc == CNT_MAX)
                            state_d = ACTIVE;
                    end else begin
                        com_cnt_d = '0;
                        state_d   = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                // Phase is frozen by the locking COM; off-phase COMs are data.
                state_d   = ACTIVE;
                bit_cnt_d = bit_cnt + 1'b1;
                if (boundary) begin
                    data_d   = sr_next;
                    valid_d  = !is_com;
                    strobe_d = 1'b1;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state       <= SEARCH;
            sr          <= '0;
            bit_cnt     <= '0;
            com_cnt     <= '0;
            data_out    <= 8'h00;
            valid_out   <= 1'b0;
            byte_strobe <= 1'b0;
            active      <= 1'b0;
        end else begin
            state       <= state_d;
            sr          <= sr_next[6:0];
            bit_cnt     <= bit_cnt_d;
            com_cnt     <= com_cnt_d;
            data_out    <= data_d;
            valid_out   <= valid_d;
            byte_strobe <= strobe_d;
            active      <= (state_d == ACTIVE);
        end
    end

endmodule

// File: tb/tb_serial_paralelo_com.sv
// Bench for serial_paralelo_com: directed and random bit streams checked
// cycle by cycle against a bit-window reference model.
module tb_serial_paralelo_com;

    localparam logic [7:0] COM = 8'hBC;
    localparam int         COM_COUNT = 4;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b1;
    logic       data_in = 1'b1;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    int checks = 0;
    int errors = 0;

    logic       bq[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    // reference model: absolute bit index, lock anchor, byte phase
    logic [7:0] m_w;
    int         m_mode;
    int         m_anchor;
    int         m_cnt;
    int         m_i;
    logic [7:0] m_d;
    logic       m_v;
    logic       m_s;

    serial_paralelo_com #(
        .COM       (COM),
        .COM_COUNT (COM_COUNT)
    ) dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .byte_strobe (byte_strobe),
        .active      (active)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_w = 8'h00;
        m_mode = 0;
        m_anchor = 0;
        m_cnt = 0;
        m_i = 0;
        m_d = 8'h00;
        m_v = 1'b0;
        m_s = 1'b0;
    endtask

    // SEARCH=0, LOCKING=1, ACTIVE=2; boundaries every 8 bits after anchor
    task automatic model_step(input logic b);
        m_w = {m_w[6:0], b};
        m_s = 1'b0;
        if (m_mode == 0) begin
            if (m_w == COM) begin
                m_anchor = m_i;
                m_cnt = 1;
                m_mode = (COM_COUNT == 1) ? 2 : 1;
            end
        end else if (((m_i - m_anchor) % 8) == 0) begin
            if (m_mode == 1) begin
                if (m_w == COM) begin
                    m_cnt++;
                    if (m_cnt == COM_COUNT) m_mode = 2;
                end else begin
                    m_mode = 0;
                    m_cnt = 0;
                end
            end else begin
                m_d = m_w;
                m_v = (m_w != COM);
                m_s = 1'b1;
            end
        end
        m_i++;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int k = 7; k >= 0; k--) bq.push_back(b[k]);
    endtask

    task automatic push_bits(input int n, input logic [31:0] v);
        for (int k = n - 1; k >= 0; k--) bq.push_back(v[k]);
    endtask

    task automatic push_lock();
        for (int k = 0; k < COM_COUNT; k++) push_byte(COM);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        data_in = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(posedge clk_32f);
            #1;
            check($sformatf("rst%0d data_out", k), data_out, 8'h00);
            check($sformatf("rst%0d valid", k), {7'd0, valid_out}, 8'h00);
            check($sformatf("rst%0d strobe", k), {7'd0, byte_strobe}, 8'h00);
            check($sformatf("rst%0d active", k), {7'd0, active}, 8'h00);
        end
        reset = 1'b0;
        model_reset();
        got_q.delete();
    endtask

    task automatic run_stream(input string name);
        for (int i = 0; i < bq.size(); i++) begin
            data_in = bq[i];
            @(posedge clk_32f);
            model_step(bq[i]);
            #1;
            check($sformatf("%s b%0d data_out", name, i), data_out, m_d);
            check($sformatf("%s b%0d valid", name, i),
                  {7'd0, valid_out}, {7'd0, m_v});
            check($sformatf("%s b%0d strobe", name, i),
                  {7'd0, byte_strobe}, {7'd0, m_s});
            check($sformatf("%s b%0d active", name, i),
                  {7'd0, active}, {7'd0, (m_mode == 2)});
            if (byte_strobe === 1'b1) got_q.push_back(data_out);
        end
        bq.delete();
    endtask

    task automatic check_bytes(input string name);
        logic [7:0] g;
        check({name, " nbytes"}, 8'(got_q.size()), 8'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            g = (k < got_q.size()) ? got_q[k] : 8'hxx;
            check($sformatf("%s byte%0d", name, k), g, exp_q[k]);
        end
        exp_q.delete();
    endtask

    initial begin
        model_reset();
        // 1: reset held with data_in=1
        do_reset(4);

        // 2: basic lock then two data bytes
        push_lock();
        push_byte(8'hA5);
        push_byte(8'h3C);
        run_stream("t2");
        exp_q = '{8'hA5, 8'h3C};
        check_bytes("t2");
        check("t2 active end", {7'd0, active}, 8'h01);

        // 3: three garbage bits before the COMs
        do_reset(2);
        push_bits(3, 32'b101);
        push_lock();
        push_byte(8'hA5);
        push_byte(8'h3C);
        run_stream("t3");
        exp_q = '{8'hA5, 8'h3C};
        check_bytes("t3");

        // 4: broken COM run falls back, then relocks
        do_reset(2);
        push_byte(COM);
        push_byte(COM);
        push_byte(8'h12);
        push_lock();
        push_byte(8'h77);
        run_stream("t4");
        exp_q = '{8'h77};
        check_bytes("t4");
        check("t4 valid", {7'd0, valid_out}, 8'h01);

        // 5: COM bytes while locked strobe with valid low
        do_reset(2);
        push_lock();
        push_byte(COM);
        push_byte(8'h55);
        push_byte(COM);
        run_stream("t5");
        exp_q = '{COM, 8'h55, COM};
        check_bytes("t5");
        check("t5 active", {7'd0, active}, 8'h01);

        // 6: reset mid-byte while locked, then a fresh lock
        do_reset(2);
        push_lock();
        push_byte(8'hA5);
        push_bits(4, 32'b1101);
        run_stream("t6a");
        do_reset(1);
        push_byte(COM);
        push_byte(COM);
        push_byte(COM);
        push_byte(8'h5A);
        push_lock();
        push_byte(8'h5A);
        run_stream("t6b");
        exp_q = '{8'h5A};
        check_bytes("t6b");

        // random: garbage prefix, lock, random payload incl. off-phase COMs
        for (int r = 0; r < 12; r++) begin
            do_reset(1);
            push_bits($urandom_range(0, 7), $urandom());
            push_lock();
            for (int k = 0; k < 6; k++) begin
                if ($urandom_range(0, 4) == 0) push_byte(COM);
                else push_byte(8'($urandom()));
            end
            run_stream($sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
